// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter/sequencer in front of a single-port memory
// with registered read data. The fetch port is read-only and the data port
// is read/write. Each access runs IDLE -> ACCESS (-> RESP for reads) -> IDLE.
// Optional build macro MEM_ARB_RR_EN selects round-robin arbitration.
// Without it, the data port has fixed priority over the fetch port.
module mem_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              r_state;
  logic                r_owner;      // 0: fetch owns the transaction, 1: data
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_din;
  logic                r_mem_re;
  logic                r_mem_we;
  logic                r_f_gnt;
  logic                r_d_gnt;
  logic                r_f_rvalid;
  logic                r_d_rvalid;
  logic [DATA_W-1:0]   r_f_rdata;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                w_pick_data;  // arbitration result, meaningful in IDLE

`ifdef MEM_ARB_RR_EN
  logic r_last_grant;  // 0: fetch granted last, 1: data granted last

  // On a conflict the port not granted last wins.
  assign w_pick_data = d_req && (!f_req || !r_last_grant);

  // Remember which port won each arbitration; reset favours fetch next.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (r_state == IDLE && (f_req || d_req)) begin
      r_last_grant <= w_pick_data;
    end
  end
`else
  // Data port always beats fetch on a conflict.
  assign w_pick_data = d_req;
`endif

  // Sequencer: arbitrate in IDLE, drive one memory strobe in ACCESS,
  // deliver read data in RESP. All outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_owner    <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_mem_re   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_f_gnt    <= 1'b0;
      r_d_gnt    <= 1'b0;
      r_f_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_f_rdata  <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_f_gnt    <= 1'b0;
      r_d_gnt    <= 1'b0;
      r_f_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      // Capture the delivered word so rdata holds between rvalid pulses.
      if (r_f_rvalid) r_f_rdata <= mem_dout;
      if (r_d_rvalid) r_d_rdata <= mem_dout;
      case (r_state)
        IDLE: begin
          if (f_req || d_req) begin
            r_owner <= w_pick_data;
            r_state <= ACCESS;
            if (w_pick_data) begin
              r_mem_addr <= d_addr;
              r_mem_din  <= d_wdata;
              r_mem_we   <= d_we;
              r_mem_re   <= !d_we;
              r_d_gnt    <= 1'b1;
            end else begin
              // Fetch never writes, so mem_din keeps its previous value.
              r_mem_addr <= f_addr;
              r_mem_we   <= 1'b0;
              r_mem_re   <= 1'b1;
              r_f_gnt    <= 1'b1;
            end
          end
        end
        ACCESS: begin
          r_mem_re <= 1'b0;
          r_mem_we <= 1'b0;
          if (r_mem_re) begin
            r_state <= RESP;
            if (r_owner) r_d_rvalid <= 1'b1;
            else         r_f_rvalid <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_addr = r_mem_addr;
  assign mem_din  = r_mem_din;
  assign mem_re   = r_mem_re;
  assign mem_we   = r_mem_we;
  assign f_gnt    = r_f_gnt;
  assign d_gnt    = r_d_gnt;
  assign f_rvalid = r_f_rvalid;
  assign d_rvalid = r_d_rvalid;
  // Read data passes straight through from the memory during the RESP cycle.
  assign f_rdata  = r_f_rvalid ? mem_dout : r_f_rdata;
  assign d_rdata  = r_d_rvalid ? mem_dout : r_d_rdata;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a behavioural
// single-port memory (registered read, image reloaded on rst).
module tb_mem_arbiter;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 18;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              f_req, d_req, d_we;
  logic [ADDR_W-1:0] f_addr, d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              f_gnt, f_rvalid, d_gnt, d_rvalid;
  logic [DATA_W-1:0] f_rdata, d_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din, mem_dout;
  logic              mem_re, mem_we, busy;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_re(mem_re), .mem_we(mem_we),
    .mem_dout(mem_dout), .busy(busy)
  );

  // Memory model
  logic [DATA_W-1:0] img [0:(1<<ADDR_W)-1];
  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) img[i] = '0;
    img[20] = 18'd42;
    img[21] = 18'd3;
    mem_dout = '0;
  end
  always @(posedge clk) begin
    if (rst) begin
      img[20] <= 18'd42;
      img[21] <= 18'd3;
    end else begin
      if (mem_we) img[mem_addr] <= mem_din;
      if (mem_re) mem_dout <= img[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  bit exp_d;
  int grants;

  initial begin
    rst = 1'b1; f_req = 0; d_req = 0; d_we = 0;
    f_addr = '0; d_addr = '0; d_wdata = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_gnt", {f_gnt, d_gnt}, 0);
    chk("rst_rvalid", {f_rvalid, d_rvalid}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_rdata", {f_rdata, d_rdata}, 0);
    rst = 1'b0;

    // Fetch read of address 20
    f_req = 1; f_addr = 13'd20;
    tick();
    $display("fetch read addr 20: gnt=%0b mem_re=%0b", f_gnt, mem_re);
    chk("f1_gnt", f_gnt, 1);
    chk("f1_dgnt", d_gnt, 0);
    chk("f1_mem_re", mem_re, 1);
    chk("f1_mem_we", mem_we, 0);
    chk("f1_mem_addr", mem_addr, 20);
    chk("f1_busy", busy, 1);
    f_req = 0;
    tick();
    chk("f1_rvalid", f_rvalid, 1);
    chk("f1_rdata", f_rdata, 42);
    chk("f1_mem_re_drop", mem_re, 0);
    chk("f1_gnt_drop", f_gnt, 0);
    tick();
    chk("f1_rvalid_drop", f_rvalid, 0);
    chk("f1_rdata_hold", f_rdata, 42);
    chk("f1_idle", busy, 0);

    // Data write 45 to address 22, then read it back
    d_req = 1; d_we = 1; d_addr = 13'd22; d_wdata = 18'd45;
    tick();
    $display("data write addr 22 data 45: gnt=%0b mem_we=%0b", d_gnt, mem_we);
    chk("w1_gnt", d_gnt, 1);
    chk("w1_mem_we", mem_we, 1);
    chk("w1_mem_re", mem_re, 0);
    chk("w1_mem_addr", mem_addr, 22);
    chk("w1_mem_din", mem_din, 45);
    d_req = 0;
    tick();
    chk("w1_mem_we_drop", mem_we, 0);
    chk("w1_idle", busy, 0);
    chk("w1_no_rvalid", d_rvalid, 0);
    d_req = 1; d_we = 0; d_addr = 13'd22;
    tick();
    chk("r1_gnt", d_gnt, 1);
    chk("r1_mem_re", mem_re, 1);
    d_req = 0;
    tick();
    $display("data read addr 22: rvalid=%0b rdata=%0d", d_rvalid, d_rdata);
    chk("r1_rvalid", d_rvalid, 1);
    chk("r1_rdata", d_rdata, 45);
    chk("r1_f_rvalid", f_rvalid, 0);
    tick();
    chk("r1_rvalid_drop", d_rvalid, 0);

    // Conflict: fetch addr 20 vs data read addr 21
    exp_d = !RR;
    f_req = 1; f_addr = 13'd20;
    d_req = 1; d_we = 0; d_addr = 13'd21;
    tick();
    $display("conflict first grant: f_gnt=%0b d_gnt=%0b", f_gnt, d_gnt);
    chk("c1_dgnt", d_gnt, exp_d);
    chk("c1_fgnt", f_gnt, !exp_d);
    if (exp_d) d_req = 0; else f_req = 0;
    tick();
    chk("c1_drv", d_rvalid, exp_d);
    chk("c1_frv", f_rvalid, !exp_d);
    chk("c1_data", exp_d ? d_rdata : f_rdata, exp_d ? 3 : 42);
    tick();
    chk("c1_idle", busy, 0);
    tick();
    $display("conflict second grant: f_gnt=%0b d_gnt=%0b", f_gnt, d_gnt);
    chk("c2_dgnt", d_gnt, !exp_d);
    chk("c2_fgnt", f_gnt, exp_d);
    f_req = 0; d_req = 0;
    tick();
    chk("c2_drv", d_rvalid, !exp_d);
    chk("c2_frv", f_rvalid, exp_d);
    chk("c2_data", exp_d ? f_rdata : d_rdata, exp_d ? 42 : 3);
    tick();

    // Both ports held for 12 cycles after a reset
    rst = 1; tick(); rst = 0;
    exp_d = !RR;
    grants = 0;
    f_req = 1; f_addr = 13'd20;
    d_req = 1; d_we = 0; d_addr = 13'd21;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("h_gnt_overlap", f_gnt & d_gnt, 0);
      chk("h_rv_overlap", f_rvalid & d_rvalid, 0);
      chk("h_strobe_overlap", mem_re & mem_we, 0);
      if (f_gnt || d_gnt) begin
        grants++;
        $display("held cycle %0d: f_gnt=%0b d_gnt=%0b", i, f_gnt, d_gnt);
        chk("h_winner", d_gnt, exp_d);
        if (RR) exp_d = !exp_d;
      end
    end
    chk("h_grant_count", grants, 4);
    f_req = 0; d_req = 0;
    tick(); tick();

    // Reset during the ACCESS cycle of a fetch read
    f_req = 1; f_addr = 13'd20;
    tick();
    chk("x_gnt", f_gnt, 1);
    f_req = 0; rst = 1;
    tick();
    $display("reset mid-read: f_rvalid=%0b busy=%0b", f_rvalid, busy);
    chk("x_rvalid", f_rvalid, 0);
    chk("x_mem_re", mem_re, 0);
    chk("x_busy", busy, 0);
    chk("x_mem_addr", mem_addr, 0);
    chk("x_gnt_drop", f_gnt, 0);
    chk("x_rdata", f_rdata, 0);
    rst = 0;
    tick();
    chk("x_no_late_rvalid", f_rvalid, 0);

    // Top-of-range address write and read back
    d_req = 1; d_we = 1; d_addr = 13'h1FFF; d_wdata = 18'h3FFFF;
    tick();
    chk("t_gnt", d_gnt, 1);
    chk("t_mem_addr", mem_addr, 13'h1FFF);
    chk("t_mem_din", mem_din, 18'h3FFFF);
    d_req = 0;
    tick();
    d_req = 1; d_we = 0;
    tick();
    chk("t_rgnt", d_gnt, 1);
    d_req = 0;
    tick();
    $display("read addr 1fff: rvalid=%0b rdata=%0h", d_rvalid, d_rdata);
    chk("t_rvalid", d_rvalid, 1);
    chk("t_rdata", d_rdata, 18'h3FFFF);
    tick();

    // Idle bus
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("i_strobes", {mem_re, mem_we}, 0);
      chk("i_busy", busy, 0);
      chk("i_gnt", {f_gnt, d_gnt}, 0);
    end
    $display("idle bus 10 cycles done");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port 18-bit unified Memory block (13-bit address, registered read data, mutually exclusive re_en/wr_en).
- Shares the memory between the instruction-fetch unit (read-only) and the load/store unit (read/write).
- Owns all memory control timing; requesters use a req/gnt/rvalid handshake.

Parameters:
ADDR_W, 13, address width of memory and both requester ports
DATA_W, 18, data word width

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous active-high reset
f_req  in  1  fetch request (read)
f_addr  in  ADDR_W  fetch address
f_gnt  out  1  fetch request accepted (1-cycle pulse)
f_rvalid  out  1  fetch read data valid (1-cycle pulse)
f_rdata  out  DATA_W  fetch read data
d_req  in  1  data-port request
d_we  in  1  data-port direction: 1 write, 0 read
d_addr  in  ADDR_W  data-port address
d_wdata  in  DATA_W  data-port write data
d_gnt  out  1  data request accepted (1-cycle pulse)
d_rvalid  out  1  data read valid (1-cycle pulse, reads only)
d_rdata  out  DATA_W  data read data
mem_addr  out  ADDR_W  to memory address
mem_din  out  DATA_W  to memory DataIn
mem_re  out  1  to memory re_en
mem_we  out  1  to memory wr_en
mem_dout  in  DATA_W  from memory DataOut
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: state=IDLE; mem_re, mem_we, f_gnt, d_gnt, f_rvalid, d_rvalid, busy = 0; mem_addr, mem_din = 0; owner = fetch; last_grant = data.
- FSM states: IDLE, ACCESS, RESP. Arbitration happens only in IDLE.
- IDLE, cycle N:
  - No request: stay in IDLE.
  - Any request: pick a winner, register its address, write data and direction into mem_addr/mem_din/mem_re/mem_we, go to ACCESS.
- ACCESS, cycle N+1:
  - Exactly one of mem_re/mem_we is high. Never both, ever.
  - Winner's gnt pulses high for this cycle only.
  - Write: next state IDLE; mem_we drops.
  - Read: next state RESP; mem_re drops.
- RESP, cycle N+2:
  - Memory has registered DataOut.
  - Owner's rvalid = 1; owner's rdata = mem_dout, passed through combinationally.
  - Next state IDLE.
- Latency from req sampled in IDLE: read gnt at +1, rvalid at +2. Write gnt at +1, write committed at end of +1.
- Throughput: one read per 3 cycles, one write per 2 cycles.
- f_rdata/d_rdata hold the last delivered value between rvalid pulses; their reset value is 0.
- Requesters must hold req, addr, we and wdata stable until gnt. The arbiter samples them only in IDLE. Changes after sampling are ignored.
- A requester may deassert req before gnt; the arbiter does not grant a request absent in IDLE.
- Fixed priority (default): data port beats fetch when both request in the same IDLE cycle.
- Simultaneous requests: the loser stays pending and is served at the next IDLE. Under fixed priority, continuous d_req starves fetch; this is by design.
- rst asserted in any state, including mid-read:
  - Next cycle is IDLE; no gnt/rvalid pulse is emitted.
  - mem_re/mem_we go low. The memory concurrently reloads its image.
- Address wrap: no arithmetic on addresses; all ADDR_W bits pass through unchanged.
- f_rvalid and d_rvalid are never high in the same cycle. f_gnt and d_gnt likewise.

Optional Feature:
MEM_ARB_RR_EN
- Defined: round-robin arbitration. On a conflict in IDLE, the port not granted last wins. last_grant updates on every grant; its reset value is data, so fetch wins the first conflict.
- Undefined: fixed priority, data over fetch; last_grant logic is not built.
- Non-conflict behaviour and all timing are identical in both builds.

Test Plan:
- Memory image Mem[20]=42: f_req, f_addr=20 held one cycle in IDLE → f_gnt at +1, f_rvalid at +2 with f_rdata=42; mem_re high exactly one cycle.
- d_req, d_we=1, d_addr=22, d_wdata=45 → d_gnt at +1, mem_we high one cycle with mem_addr=22, mem_din=45; then d_req read of 22 → d_rvalid with d_rdata=45.
- f_req (addr 20) and d_req read (addr 21, value 3) in the same cycle, fixed priority → d_rvalid data=3 first, then f_rvalid data=42 three cycles later. With MEM_ARB_RR_EN → fetch is served first.
- Both requests held high for 12 cycles with MEM_ARB_RR_EN → grants alternate f,d,f,d; no overlap of gnt/rvalid; mem_re and mem_we never both high.
- rst asserted in the ACCESS cycle of a read → no f_rvalid, all outputs 0 the next cycle, busy=0; a new request after rst works normally.
- Idle bus for 10 cycles, no requests → mem_re=mem_we=0, busy=0, no gnt pulses.
